sensor_debounce: RTL and testbench



---
 rtl/sensor_pkg.sv | 15 +
 rtl/debounce_bit.sv | 48 ++++
 rtl/sensor_debounce.sv | 66 ++++++
 tb/tb_sensor_debounce.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor debouncer: default sizes, the sensor
// vector type and the error rule applied to the stable vector.
package sensor_pkg;

  localparam int NUM_SENSORS_DEF     = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 8;

  typedef logic [3:0] sensor_vec_t;

  // Error whenever sensor 0 is active, or sensor 1 together with 2 or 3
  function automatic logic sensor_err(sensor_vec_t s);
    return s[0] | (s[1] & (s[2] | s[3]));
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One sensor line: two-flop synchroniser, consecutive-sample counter and
// stable flop. stable_next exposes the value stable takes on the next edge.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic raw,
  output logic stable,
  output logic stable_next
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Any sample that agrees with the stable value restarts the count
  always_comb begin
    stable_next = stable;
    cnt_next    = '0;
    if (sync_q2 != stable) begin
      if (cnt == CNT_LAST) begin
        stable_next = sync_q2;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      stable  <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      cnt     <= cnt_next;
      stable  <= stable_next;
    end
  end

endmodule

// File: rtl/sensor_debounce.sv
// Debounces NUM_SENSORS raw lines and derives a change strobe and error flag.
// Define SENSOR_ERR_LATCH_EN to make error sticky until cleared by clear_err.
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int NUM_SENSORS     = NUM_SENSORS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NUM_SENSORS-1:0] sensors_raw,
  input  logic                   clear_err,
  output logic [NUM_SENSORS-1:0] sensors,
  output logic                   changed,
  output logic                   error
);

  logic [NUM_SENSORS-1:0] stable_next;
  logic                   err_next;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk        (clk),
      .n_rst      (n_rst),
      .raw        (sensors_raw[i]),
      .stable     (sensors[i]),
      .stable_next(stable_next[i])
    );
  end

  // Both flags look at the next-state vector so they line up with sensors
  assign err_next = sensor_err(stable_next[3:0]);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      changed <= 1'b0;
    end else begin
      changed <= |(stable_next ^ sensors);
    end
  end

`ifdef SENSOR_ERR_LATCH_EN
  // A new error wins over a simultaneous clear
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      error <= 1'b0;
    end else begin
      error <= err_next | (error & ~clear_err);
    end
  end
`else
  logic unused_clear_err;
  assign unused_clear_err = clear_err;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      error <= 1'b0;
    end else begin
      error <= err_next;
    end
  end
`endif

endmodule

// File: tb/tb_sensor_debounce.sv
// Directed bench for sensor_debounce (DEBOUNCE_CYCLES=8 plus a =1 instance);
// expectations follow SENSOR_ERR_LATCH_EN when it is defined.
module tb_sensor_debounce;

`ifdef SENSOR_ERR_LATCH_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] sensors_raw;
  logic       clear_err;
  logic [3:0] sensors;
  logic       changed;
  logic       error;

  logic [3:0] raw1;
  logic       clr1;
  logic [3:0] sensors1;
  logic       changed1;
  logic       error1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] raw;
    logic       clr;
    int         cycles;
    logic [3:0] exp_s;
    logic       exp_ch;
    logic       err_plain;
    logic       err_sticky;
  } vec_t;

  vec_t vecs[13];

  sensor_debounce dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .sensors_raw(sensors_raw),
    .clear_err  (clear_err),
    .sensors    (sensors),
    .changed    (changed),
    .error      (error)
  );

  sensor_debounce #(.NUM_SENSORS(4), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk        (clk),
    .n_rst      (n_rst),
    .sensors_raw(raw1),
    .clear_err  (clr1),
    .sensors    (sensors1),
    .changed    (changed1),
    .error      (error1)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string name, input logic [3:0] exp_s,
                              input logic exp_ch, input logic exp_err);
    check_val({name, " sensors"}, {4'b0, sensors}, {4'b0, exp_s});
    check_val({name, " changed"}, {7'b0, changed}, {7'b0, exp_ch});
    check_val({name, " error"},   {7'b0, error},   {7'b0, exp_err});
  endtask

  task automatic apply_stimulus(input logic [3:0] raw, input logic clr, input int n);
    sensors_raw = raw;
    clear_err   = clr;
    step(n);
    clear_err   = 1'b0;
  endtask

  initial begin
    // raw, clr, cycles, sensors, changed, error (plain), error (sticky)
    vecs[0]  = '{4'b0001, 1'b0,  9, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0001, 1'b0,  1, 4'b0001, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{4'b0001, 1'b0,  1, 4'b0001, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{4'b0000, 1'b0, 10, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{4'b0000, 1'b1,  1, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'b1010, 1'b0, 10, 4'b1010, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{4'b1010, 1'b0,  1, 4'b1010, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{4'b0010, 1'b0, 10, 4'b0010, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{4'b0010, 1'b1,  1, 4'b0010, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'b0011, 1'b0, 10, 4'b0011, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{4'b0011, 1'b1,  1, 4'b0011, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{4'b0000, 1'b0, 10, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{4'b0000, 1'b1,  1, 4'b0000, 1'b0, 1'b0, 1'b0};

    n_rst       = 1'b0;
    sensors_raw = 4'b1111;
    clear_err   = 1'b0;
    raw1        = 4'b0000;
    clr1        = 1'b0;

    $display("[TB] reset with all lines high");
    step(3);
    check_output("reset", 4'b0000, 1'b0, 1'b0);
    n_rst       = 1'b1;
    sensors_raw = 4'b0000;
    step(2);
    check_output("after reset", 4'b0000, 1'b0, 1'b0);

    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].raw, vecs[i].clr, vecs[i].cycles);
      check_output($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_ch,
                   STICKY ? vecs[i].err_sticky : vecs[i].err_plain);
    end

    $display("[TB] reset in the middle of a count");
    apply_stimulus(4'b1111, 1'b0, 10);
    check_output("all high", 4'b1111, 1'b1, 1'b1);
    apply_stimulus(4'b0000, 1'b0, 5);
    check_output("mid count", 4'b1111, 1'b0, 1'b1);
    sensors_raw = 4'b1111;
    n_rst = 1'b0;
    #1;
    check_output("async reset", 4'b0000, 1'b0, 1'b0);
    step(3);
    check_output("reset held", 4'b0000, 1'b0, 1'b0);
    n_rst = 1'b1;
    step(9);
    check_output("post reset 9", 4'b0000, 1'b0, 1'b0);
    step(1);
    check_output("post reset 10", 4'b1111, 1'b1, 1'b1);
    apply_stimulus(4'b0000, 1'b0, 10);
    check_output("release all", 4'b0000, 1'b1, STICKY);
    apply_stimulus(4'b0000, 1'b1, 1);
    check_output("clear", 4'b0000, 1'b0, 1'b0);

    $display("[TB] 7-cycle glitch on bit 2");
    for (int i = 0; i < 20; i++) begin
      sensors_raw = (i < 7) ? 4'b0100 : 4'b0000;
      step(1);
      check_output($sformatf("glitch c%0d", i), 4'b0000, 1'b0, 1'b0);
    end

    $display("[TB] dip inside a high pulse on bit 2");
    for (int i = 0; i < 17; i++) begin
      sensors_raw = (i < 4 || i >= 7) ? 4'b0100 : 4'b0000;
      step(1);
      if (i < 16) check_output($sformatf("dip c%0d", i), 4'b0000, 1'b0, 1'b0);
      else        check_output("dip update", 4'b0100, 1'b1, 1'b0);
    end
    apply_stimulus(4'b0000, 1'b0, 10);
    check_output("dip release", 4'b0000, 1'b1, 1'b0);

    $display("[TB] DEBOUNCE_CYCLES=1 instance");
    raw1 = 4'b0001;
    step(1);
    raw1 = 4'b0000;
    step(1);
    check_val("dc1 edge2 sensors", {4'b0, sensors1}, 8'h00);
    step(1);
    check_val("dc1 edge3 sensors", {4'b0, sensors1}, 8'h01);
    check_val("dc1 edge3 changed", {7'b0, changed1}, 8'h01);
    check_val("dc1 edge3 error",   {7'b0, error1},   8'h01);
    step(1);
    check_val("dc1 edge4 sensors", {4'b0, sensors1}, 8'h00);
    check_val("dc1 edge4 changed", {7'b0, changed1}, 8'h01);
    check_val("dc1 edge4 error",   {7'b0, error1},   {7'b0, STICKY});
    step(1);
    check_val("dc1 edge5 changed", {7'b0, changed1}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
